// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: counter encodings, default table size and
// the record carried through the F->D and D->E pipeline registers.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam int DEFAULT_IDX_BITS = 4;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [31:0] pc;
    } pipe_rec_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolution signals of the branch predictor.
// The pipeline/hazard logic is the master; the predictor is the slave.
interface branch_predictor_if;
    logic [31:0] PCF;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        BranchE;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        MispredictE;
    logic [31:0] CorrectPCE;

    modport master (
        output PCF, StallF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE,
        input  PredTakenF, PredTargetF, MispredictE, CorrectPCE
    );

    modport slave (
        input  PCF, StallF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE,
        output PredTakenF, PredTargetF, MispredictE, CorrectPCE
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_e'(ctr_i + 2'd1);
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, prediction pipeline F->D->E and mispredict
// detection. Define BP_STATS_EN to add BranchCount/MispredCount statistics outputs.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_predictor_if.slave        bp
`ifdef BP_STATS_EN
    ,
    output logic [15:0]              BranchCount,
    output logic [15:0]              MispredCount
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [31:0]       target_d [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];
    ctr_e              ctr_d    [ENTRIES];

    pipe_rec_t fd_q, fd_d, de_q, de_d;

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_W-1:0]    f_tag, e_tag;
    logic                f_hit, e_hit;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic                mispredict;
    ctr_e                ctr_upd;

    assign f_idx = bp.PCF[IDX_BITS+1:2];
    assign f_tag = bp.PCF[31:IDX_BITS+2];
    assign e_idx = de_q.pc[IDX_BITS+1:2];
    assign e_tag = de_q.pc[31:IDX_BITS+2];

    // Outputs are forced to their idle values while reset is asserted, not just after it.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = reset && f_hit && ctr_q[f_idx][1];
        pred_target = pred_taken ? target_q[f_idx] : bp.PCF + 32'd4;
        e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        mispredict  = reset && bp.BranchE &&
                      ((bp.BranchTakenE != de_q.pred_taken) ||
                       (bp.BranchTakenE && (de_q.pred_target != bp.BranchTargetE)));
    end

    assign bp.PredTakenF  = pred_taken;
    assign bp.PredTargetF = pred_target;
    assign bp.MispredictE = mispredict;
    assign bp.CorrectPCE  = !reset ? 32'd4 :
                            (bp.BranchTakenE ? bp.BranchTargetE : de_q.pc + 32'd4);

    bp_sat_counter u_sat_counter (
        .ctr_i   (ctr_q[e_idx]),
        .taken_i (bp.BranchTakenE),
        .ctr_o   (ctr_upd)
    );

    // Flush beats stall on the decode register.
    always_comb begin
        fd_d = fd_q;
        if (bp.FlushD) begin
            fd_d = '0;
        end else if (!bp.StallD) begin
            fd_d = '{pred_taken: pred_taken, pred_target: pred_target, pc: bp.PCF};
        end
        de_d = bp.FlushE ? '0 : fd_q;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        if (bp.BranchE) begin
            if (e_hit) begin
                ctr_d[e_idx] = ctr_upd;
                if (bp.BranchTakenE) target_d[e_idx] = bp.BranchTargetE;
            end else if (bp.BranchTakenE) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = bp.BranchTargetE;
                ctr_d[e_idx]    = WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            fd_q <= '0;
            de_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            fd_q <= fd_d;
            de_q <= de_d;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.BranchE && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
        if (mispredict && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, giving a table of 2^IDX_BITS entries indexed by PC[IDX_BITS+1:2].
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low (reset=0 clears state at the next rising clk edge).
REQ-004 SHALL have port PCF, input, 32, the fetch-stage PC.
REQ-005 SHALL have ports StallF and StallD, input, 1 each, the fetch/decode hold requests from the hazard unit.
REQ-006 SHALL have ports FlushD and FlushE, input, 1 each, the decode/execute bubble requests.
REQ-007 SHALL have port BranchE, input, 1, meaning a valid branch is resolving in execute (already qualified by FlushE upstream).
REQ-008 SHALL have port BranchTakenE, input, 1, the resolved direction from condition logic.
REQ-009 SHALL have port BranchTargetE, input, 32, the resolved branch target.
REQ-010 SHALL have port PredTakenF, output, 1, the fetch-stage taken prediction.
REQ-011 SHALL have port PredTargetF, output, 32, the next-PC selected by the prediction.
REQ-012 SHALL have port MispredictE, output, 1, meaning redirect fetch this cycle.
REQ-013 SHALL have port CorrectPCE, output, 32, the redirect address.

Function
REQ-014 SHALL store per entry: valid, tag PC[31:IDX_BITS+2], 32-bit target, 2-bit saturating counter.
REQ-015 SHALL compute lookup combinationally: hit = valid && tag match; PredTakenF = hit && ctr[1]; PredTargetF = target if PredTakenF, else PCF+4.
REQ-016 SHALL carry {PredTaken, PredTarget, PC} through F->D and D->E pipeline registers.
REQ-017 SHALL hold the F->D register while StallD=1.
REQ-018 SHALL clear the F->D register (PredTaken=0) while FlushD=1; flush overrides stall.
REQ-019 SHALL clear the D->E register while FlushE=1.
REQ-020 SHALL compute MispredictE = BranchE && (BranchTakenE != PredTakenE || (BranchTakenE && PredTargetE != BranchTargetE)), combinationally in the same cycle.
REQ-021 SHALL drive CorrectPCE = BranchTakenE ? BranchTargetE : PCE+4.
REQ-022 SHALL, when BranchE=1 and the entry hits at the clock edge, increment ctr on taken and decrement on not-taken, saturating at 3 and 0, and refresh target on taken.
REQ-023 SHALL, when BranchE=1, miss and taken, allocate the entry: valid=1, new tag, target=BranchTargetE, ctr=2 (weakly taken).
REQ-024 SHALL NOT allocate on a miss that resolves not-taken.
REQ-025 SHALL give a same-cycle lookup of the entry being updated the pre-update contents (no bypass).
REQ-026 SHALL leave StallF without effect on table state; it only concerns the upstream PC register.

Reset
REQ-027 SHALL, on reset=0, clear all valid bits, set all counters to 1, and clear both pipeline registers.
REQ-028 SHALL, during and after reset, drive PredTakenF=0, PredTargetF=PCF+4, MispredictE=0, CorrectPCE=4.
REQ-029 SHALL give reset priority over stall, flush and update.

Configuration
REQ-030 SHALL, with BP_STATS_EN defined, add outputs BranchCount[15:0] and MispredCount[15:0]: BranchCount counts cycles with BranchE=1, MispredCount counts cycles with MispredictE=1; both saturate at 16'hFFFF and reset to 0.
REQ-031 SHALL, without BP_STATS_EN, have neither port nor counter logic.

Structure
REQ-032 SHALL place in a shared package: counter encodings (SNT=0, WNT=1, WT=2, ST=3), the default IDX_BITS, and the pipeline-register record type.
REQ-033 SHALL use one sub-module, bp_sat_counter, for the 2-bit saturating next-state logic.

Verification
REQ-034 SHALL cover: reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-035 SHALL cover: branch at 0x100 resolves taken to 0x200 -> MispredictE=1, CorrectPCE=0x200; next fetch of 0x100 -> PredTakenF=1, PredTargetF=0x200.
REQ-036 SHALL cover: same branch resolves not-taken twice -> ctr 2->1->0; the first not-taken gives MispredictE=1 and CorrectPCE=0x104; the next fetch gives PredTakenF=0.
REQ-037 SHALL cover: four consecutive taken resolutions -> ctr saturates at 3; one not-taken -> ctr=2 and the prediction stays taken.
REQ-038 SHALL cover: StallD=1 and FlushD=1 in the same cycle with PredTakenF=1 -> the decode stage carries PredTaken=0.
REQ-039 SHALL cover, with BP_STATS_EN: 3 branches of which 1 is mispredicted -> BranchCount=3, MispredCount=1; and reset mid-count -> both counters read 0.
